// File: rtl/layernorm_mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// layernorm_mul_arb_pkg
//   Shared definitions for the layernorm multiplier arbiter:
//   - default operand/product widths (25-bit unsigned x 19-bit signed)
//   - clog2 helper used to size requester tags
//   - tag type wide enough for the largest supported requester count (8)
// ---------------------------------------------------------------------------
package layernorm_mul_arb_pkg;

   localparam int PKG_DIN0_W = 25;
   localparam int PKG_DIN1_W = 19;
   localparam int PKG_DOUT_W = PKG_DIN0_W + PKG_DIN1_W;

   localparam int MAX_REQ   = 8;
   localparam int MAX_TAG_W = 3;

   typedef logic [MAX_TAG_W-1:0] tag_t;

   // Smallest r with 2**r >= v (returns 1 for v <= 2 so tags are never 0 bits wide).
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/layernorm_mul_arbiter_core.sv
// ---------------------------------------------------------------------------
// layernorm_mul_core
//   Stage-2 product register of the shared multiplier.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (product clears to 0)
//     en         : load a new product this cycle, otherwise hold
//     din0       : unsigned operand (DIN0_W bits)
//     din1       : signed operand (DIN1_W bits)
//     dout       : registered signed product (DOUT_W bits)
// ---------------------------------------------------------------------------
module layernorm_mul_core #(
   parameter int DIN0_W = 25,
   parameter int DIN1_W = 19,
   parameter int DOUT_W = 44
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIN0_W-1:0] din0,
   input  logic [DIN1_W-1:0] din1,
   output logic [DOUT_W-1:0] dout
);

   logic [DOUT_W-1:0] din0_ext;
   logic [DOUT_W-1:0] din1_ext;
   logic [DOUT_W-1:0] dout_d;
   logic [DOUT_W-1:0] dout_q;

   // Both operands are extended to the full product width first, so a plain
   // modulo-2^DOUT_W multiply yields the exact signed product.
   always_comb begin
      din0_ext = {{(DOUT_W-DIN0_W){1'b0}}, din0};
      din1_ext = {{(DOUT_W-DIN1_W){din1[DIN1_W-1]}}, din1};
      dout_d   = en ? (din0_ext * din1_ext) : dout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule

// File: rtl/layernorm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// layernorm_mul_arbiter
//   Shares one DIN0_W x DIN1_W multiplier among N_REQ requesters.
//   Stage 1 registers the granted operands and tag, stage 2 (layernorm_mul_core)
//   registers the product. Each result carries the issuing requester's tag.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; valid and payload must stay stable until that edge. ready never
//   depends on the same port's valid being low, and at most one req_ready bit
//   is set per cycle.
//
//   Ports:
//     ap_clk, ap_rst_n      : clock, asynchronous active-low reset
//     req_valid/req_ready   : per-requester handshake (N_REQ bits)
//     req_din0/req_din1     : packed operands, requester i at [i*W +: W]
//     out_valid/out_ready   : result handshake
//     out_dout, out_tag     : signed product and issuing requester index
//     busy                  : any pipeline stage holds a valid item
//
//   Build option MUL_ARB_FIXED_PRIO_EN: fixed priority (requester 0 highest)
//   instead of round-robin; the round-robin pointer is then tied to 0.
// ---------------------------------------------------------------------------
module layernorm_mul_arbiter
   import layernorm_mul_arb_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int DIN0_W = PKG_DIN0_W,
   parameter  int DIN1_W = PKG_DIN1_W,
   parameter  int DOUT_W = PKG_DOUT_W,
   localparam int TAG_W  = clog2(N_REQ)
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DIN0_W-1:0] req_din0,
   input  logic [N_REQ*DIN1_W-1:0] req_din1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DOUT_W-1:0]       out_dout,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    busy
);

   localparam logic [TAG_W:0] N_REQ_T = (TAG_W+1)'(N_REQ);

   logic              s1_valid_q, s1_valid_d;
   logic [DIN0_W-1:0] din0_s1_q,  din0_s1_d;
   logic [DIN1_W-1:0] din1_s1_q,  din1_s1_d;
   logic [TAG_W-1:0]  tag_s1_q,   tag_s1_d;
   logic              s2_valid_q, s2_valid_d;
   logic [TAG_W-1:0]  tag_s2_q,   tag_s2_d;

   logic              s1_en, s2_en;
   logic [TAG_W-1:0]  rr_ptr;
   logic [N_REQ-1:0]  req_rot;
   logic [TAG_W-1:0]  rot_pos;
   logic [TAG_W:0]    idx_sum;
   logic [TAG_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  grant;
   logic              grant_any;
   logic              accept;
   logic [DIN0_W-1:0] din0_sel;
   logic [DIN1_W-1:0] din1_sel;

   assign s2_en = !s2_valid_q | out_ready;
   assign s1_en = !s1_valid_q | s2_en;

   // Rotate requests so the current pointer sits at bit 0, take the lowest
   // set bit, then rotate the position back to a requester index.
   always_comb begin
      req_rot   = N_REQ'({req_valid, req_valid} >> rr_ptr);
      grant_any = |req_rot;
      rot_pos   = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (req_rot[i]) rot_pos = TAG_W'(i);
      end
      idx_sum = {1'b0, rot_pos} + {1'b0, rr_ptr};
      if (idx_sum >= N_REQ_T) idx_sum = idx_sum - N_REQ_T;
      grant_idx        = idx_sum[TAG_W-1:0];
      grant            = '0;
      grant[grant_idx] = grant_any;
   end

   assign req_ready = grant & {N_REQ{s1_en}};
   assign accept    = grant_any & s1_en;

   always_comb begin
      din0_sel = '0;
      din1_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            din0_sel = req_din0[i*DIN0_W +: DIN0_W];
            din1_sel = req_din1[i*DIN1_W +: DIN1_W];
         end
      end
   end

`ifdef MUL_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W:0]   rr_nxt;

   // Pointer moves past the winner only when a transfer actually happens.
   always_comb begin
      rr_nxt = {1'b0, grant_idx} + 1'b1;
      if (rr_nxt >= N_REQ_T) rr_nxt = '0;
      rr_ptr_d = accept ? rr_nxt[TAG_W-1:0] : rr_ptr_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) rr_ptr_q <= '0;
      else           rr_ptr_q <= rr_ptr_d;
   end

   assign rr_ptr = rr_ptr_q;
`endif

   always_comb begin
      s1_valid_d = s1_valid_q;
      din0_s1_d  = din0_s1_q;
      din1_s1_d  = din1_s1_q;
      tag_s1_d   = tag_s1_q;
      if (s1_en) begin
         s1_valid_d = accept;
         if (accept) begin
            din0_s1_d = din0_sel;
            din1_s1_d = din1_sel;
            tag_s1_d  = grant_idx;
         end
      end
      s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
      tag_s2_d   = s2_en ? tag_s1_q   : tag_s2_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_valid_q <= 1'b0;
         din0_s1_q  <= '0;
         din1_s1_q  <= '0;
         tag_s1_q   <= '0;
         s2_valid_q <= 1'b0;
         tag_s2_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         din0_s1_q  <= din0_s1_d;
         din1_s1_q  <= din1_s1_d;
         tag_s1_q   <= tag_s1_d;
         s2_valid_q <= s2_valid_d;
         tag_s2_q   <= tag_s2_d;
      end
   end

   layernorm_mul_core #(
      .DIN0_W (DIN0_W),
      .DIN1_W (DIN1_W),
      .DOUT_W (DOUT_W)
   ) u_core (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .en    (s2_en),
      .din0  (din0_s1_q),
      .din1  (din1_s1_q),
      .dout  (out_dout)
   );

   assign out_valid = s2_valid_q;
   assign out_tag   = tag_s2_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_layernorm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_layernorm_mul_arbiter
//   Directed bench for layernorm_mul_arbiter (N_REQ=4, 25x19 -> 44 bits).
//   Inputs change 1 time unit after the rising edge; outputs are read at the
//   same point, combinational req_ready one further unit later.
// ---------------------------------------------------------------------------
module tb_layernorm_mul_arbiter;

   localparam int N_REQ  = 4;
   localparam int DIN0_W = 25;
   localparam int DIN1_W = 19;
   localparam int DOUT_W = 44;
   localparam int TAG_W  = 2;

   logic                    ap_clk = 1'b0;
   logic                    ap_rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*DIN0_W-1:0] req_din0;
   logic [N_REQ*DIN1_W-1:0] req_din1;
   logic                    out_valid;
   logic                    out_ready;
   logic [DOUT_W-1:0]       out_dout;
   logic [TAG_W-1:0]        out_tag;
   logic                    busy;

   int n_vec = 0;
   int n_err = 0;

   logic [TAG_W+DOUT_W-1:0] exp_q[$];

   layernorm_mul_arbiter dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din0  (req_din0),
      .req_din1  (req_din1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dout  (out_dout),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_req(input int i, input logic v, input logic [DIN0_W-1:0] d0,
                            input logic [DIN1_W-1:0] d1);
      req_valid[i]                   = v;
      req_din0[i*DIN0_W +: DIN0_W]   = d0;
      req_din1[i*DIN1_W +: DIN1_W]   = d1;
   endtask

   task automatic idle_all();
      req_valid = '0;
      req_din0  = '0;
      req_din1  = '0;
   endtask

   task automatic apply_reset();
      idle_all();
      out_ready = 1'b1;
      ap_rst_n  = 1'b0;
      tick();
      tick();
      ap_rst_n  = 1'b1;
      tick();
   endtask

   // Reference product: exact signed arithmetic in 64 bits, truncated to 44.
   function automatic logic [DOUT_W-1:0] model_mul(input logic [DIN0_W-1:0] a,
                                                   input logic [DIN1_W-1:0] b);
      longint p;
      p = longint'(a) * longint'($signed(b));
      return p[DOUT_W-1:0];
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_all();
      out_ready = 1'b1;
      ap_rst_n  = 1'b0;
      #3;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
      n_vec++; if (out_dout !== 44'h0) begin n_err++; $display("FAIL rst_out_dout: got %h want 0", out_dout); end
      n_vec++; if (out_tag !== 2'd0) begin n_err++; $display("FAIL rst_out_tag: got %0d want 0", out_tag); end
      tick();
      ap_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive_req(0, 1'b1, 25'd3, -19'sd5);
      settle();
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      tick();
      drive_req(0, 1'b0, '0, '0);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat1_valid: got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_lat1_busy: got %b want 1", busy); end
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
      n_vec++; if (out_dout !== 44'hFFFFFFFFFF1) begin n_err++; $display("FAIL single_dout: got %h want fffffffff1", out_dout); end
      n_vec++; if (out_tag !== 2'd0) begin n_err++; $display("FAIL single_tag: got %0d want 0", out_tag); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_drain_busy: got %b want 0", busy); end
   endtask

   // Pointer is 1 here (after the req0 transfer); req2 is the only requester.
   task automatic test_extremes();
      out_ready = 1'b1;
      drive_req(2, 1'b1, 25'h1FFFFFF, 19'h40000);
      settle();
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ext_ready0: got %b want 0100", req_ready); end
      tick();
      drive_req(2, 1'b1, 25'h1FFFFFF, 19'h3FFFF);
      settle();
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ext_ready1: got %b want 0100", req_ready); end
      tick();
      drive_req(2, 1'b0, '0, '0);
      // (2^25-1) * -2^18 = -2^43 + 2^18
      n_vec++; if (out_valid !== 1'b1 || out_dout !== 44'h80000040000 || out_tag !== 2'd2) begin
         n_err++; $display("FAIL ext_min: got v=%b %h tag %0d want v=1 80000040000 tag 2", out_valid, out_dout, out_tag); end
      tick();
      // (2^25-1) * (2^18-1) = 2^43 - 2^25 - 2^18 + 1
      n_vec++; if (out_valid !== 1'b1 || out_dout !== 44'h7FFFDFC0001 || out_tag !== 2'd2) begin
         n_err++; $display("FAIL ext_max: got v=%b %h tag %0d want v=1 7fffdfc0001 tag 2", out_valid, out_dout, out_tag); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ext_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [DIN0_W-1:0] bb_d0[4];
      logic [DIN1_W-1:0] bb_d1[4];
      logic [TAG_W+DOUT_W-1:0] exp_item;
      bb_d0[0] = 25'd1000;    bb_d1[0] = -19'sd300;
      bb_d0[1] = 25'd2017;    bb_d1[1] = 19'd301;
      bb_d0[2] = 25'h1ABCDEF; bb_d1[2] = -19'sd1;
      bb_d0[3] = 25'd7;       bb_d1[3] = 19'h3FFFF;
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < N_REQ; i++) drive_req(i, 1'b1, bb_d0[i], bb_d1[i]);
      for (int c = 0; c < 10; c++) begin
         if (c >= 2) begin
            exp_item = exp_q.pop_front();
            n_vec++; if (out_valid !== 1'b1 || {out_tag, out_dout} !== exp_item) begin
               n_err++; $display("FAIL b2b_out c%0d: got v=%b tag %0d %h want v=1 tag %0d %h",
                                 c, out_valid, out_tag, out_dout, exp_item[DOUT_W +: TAG_W], exp_item[DOUT_W-1:0]); end
         end
         if (c == 8) idle_all();
         settle();
         if (c < 8) begin
            n_vec++; if (req_ready !== 4'(1 << (c % 4))) begin
               n_err++; $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
            exp_q.push_back({TAG_W'(c % 4), model_mul(bb_d0[c % 4], bb_d1[c % 4])});
         end
         tick();
      end
      n_vec++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL b2b_end: got v=%b pending %0d want v=0 pending 0", out_valid, exp_q.size()); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready = 1'b0;
      drive_req(1, 1'b1, 25'd7, -19'sd9);       // A
      drive_req(2, 1'b1, 25'd12345, 19'd100);   // B
      settle();
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ready_c0: got %b want 0010", req_ready); end
      tick();
      drive_req(1, 1'b1, 25'h1000000, 19'd3);   // D, second item from req1
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_c1: got %b want 0", out_valid); end
      settle();
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_ready_c1: got %b want 0100", req_ready); end
      tick();
      drive_req(2, 1'b0, '0, '0);
      for (int c = 2; c < 5; c++) begin
         n_vec++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_dout !== 44'hFFFFFFFFFC1) begin
            n_err++; $display("FAIL bp_hold c%0d: got v=%b tag %0d %h want v=1 tag 1 fffffffffc1", c, out_valid, out_tag, out_dout); end
         settle();
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ready c%0d: got %b want 0000", c, req_ready); end
         tick();
      end
      out_ready = 1'b1;
      n_vec++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_dout !== 44'hFFFFFFFFFC1) begin
         n_err++; $display("FAIL bp_hold c5: got v=%b tag %0d %h want v=1 tag 1 fffffffffc1", out_valid, out_tag, out_dout); end
      settle();
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ready_c5: got %b want 0010", req_ready); end
      tick();
      drive_req(1, 1'b0, '0, '0);
      n_vec++; if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_dout !== 44'd1234500) begin
         n_err++; $display("FAIL bp_drain_b: got v=%b tag %0d %h want v=1 tag 2 %h", out_valid, out_tag, out_dout, 44'd1234500); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_dout !== 44'h3000000) begin
         n_err++; $display("FAIL bp_drain_d: got v=%b tag %0d %h want v=1 tag 1 3000000", out_valid, out_tag, out_dout); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL bp_empty: got v=%b busy=%b want 0 0", out_valid, busy); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = 1'b0;
      drive_req(0, 1'b1, 25'd5, 19'd6);
      drive_req(1, 1'b1, 25'd8, 19'd9);
      tick();
      drive_req(0, 1'b0, '0, '0);
      tick();
      drive_req(1, 1'b0, '0, '0);
      n_vec++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL rmid_full: got v=%b busy=%b want 1 1", out_valid, busy); end
      #2;
      ap_rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL rmid_async: got v=%b busy=%b want 0 0", out_valid, busy); end
      n_vec++; if (out_dout !== 44'h0 || out_tag !== 2'd0) begin
         n_err++; $display("FAIL rmid_clear: got %h tag %0d want 0 tag 0", out_dout, out_tag); end
      tick();
      ap_rst_n  = 1'b1;
      out_ready = 1'b1;
      tick();
      drive_req(0, 1'b1, 25'd11, 19'd3);
      drive_req(2, 1'b1, 25'd4, 19'd4);
      settle();
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
      tick();
      idle_all();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale: got %b want 0", out_valid); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_dout !== 44'd33) begin
         n_err++; $display("FAIL rmid_result: got v=%b tag %0d %h want v=1 tag 0 21", out_valid, out_tag, out_dout); end
      tick();
      tick();
   endtask

   task automatic test_priority();
      logic [N_REQ-1:0] exp_rdy[4];
`ifdef MUL_ARB_FIXED_PRIO_EN
      exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b0001; exp_rdy[3] = 4'b1000;
`else
      exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b1000; exp_rdy[2] = 4'b0001; exp_rdy[3] = 4'b1000;
`endif
      apply_reset();
      drive_req(0, 1'b1, 25'd2, 19'd2);
      drive_req(3, 1'b1, 25'd3, 19'd3);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) drive_req(0, 1'b0, '0, '0);
         settle();
         n_vec++; if (req_ready !== exp_rdy[c]) begin
            n_err++; $display("FAIL prio_ready c%0d: got %b want %b", c, req_ready, exp_rdy[c]); end
         tick();
      end
      idle_all();
      tick();
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL prio_drain: got busy=%b want 0", busy); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      idle_all();
      out_ready = 1'b1;
      ap_rst_n  = 1'b0;
      test_reset();
      test_single();
      test_extremes();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_priority();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
